// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit path.
// The line encoding is {dplus, dminus} so a line state can be split
// straight onto the two pad drivers.
package usb_pkg;

  // Transmit sequencer states. A state describes the action taken at the
  // next shift_enable strobe; the line register shows the result one cycle
  // after that strobe.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    STUFF = 3'd2,
    SE0_1 = 3'd3,
    SE0_2 = 3'd4,
    EOP_J = 3'd5
  } tx_state_e;

  // Number of consecutive transmitted 1s that forces a stuffed 0.
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Line states as {dplus, dminus}.
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // NRZI transition: J <-> K. SE0 is never toggled in normal operation;
  // mapping it to K keeps the function total without extra state.
  function automatic logic [1:0] line_toggle(input logic [1:0] cur);
    return (cur == LINE_K) ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI line register. Holds the current {dplus, dminus} level and applies
// one of four actions per cycle: force J, force SE0, toggle, or hold.
// The sequencer decides when; this block only owns the line level.
module usb_nrzi_enc
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  input  logic force_se0,
  input  logic force_j,
  output logic dplus_out,
  output logic dminus_out
);

  logic [1:0] line_q;

  // Line register: reset and force_j win so a new packet always starts
  // its NRZI reference from J; toggle encodes a data 0 or a stuff bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= LINE_J;
    end else if (force_j) begin
      line_q <= LINE_J;
    end else if (force_se0) begin
      line_q <= LINE_SE0;
    end else if (toggle) begin
      line_q <= line_toggle(line_q);
    end
  end

  assign dplus_out  = line_q[1];
  assign dminus_out = line_q[0];

endmodule

// File: rtl/usb_tx_encode.sv
// USB transmit encoder: NRZI, bit stuffing and EOP generation.
//
// Data handshake: tx_bit/tx_last are treated as always valid; bit_req is
// the ready. A bit transfers in exactly the cycle bit_req=1 (state DATA
// with shift_enable=1), and the upstream shifter must advance on that
// cycle only. Stuff and EOP slots keep bit_req low so no data is lost.
//
// All sequencing happens on shift_enable strobes, with one exception:
// tx_start in IDLE moves to DATA on any edge. That edge never consumes a
// bit, so the first data bit goes out on the next strobe.
module usb_tx_encode
  import usb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      shift_enable,
  input  logic      tx_start,
  input  logic      tx_bit,
  input  logic      tx_last,
  output logic      bit_req,
  output logic      dplus_out,
  output logic      dminus_out,
  output logic      tx_busy,
  output logic      eop_done,
  output tx_state_e state_dbg
);

  tx_state_e  state, state_next;
  logic [2:0] ones_cnt, ones_next;
  logic       last_pend, last_pend_next;
  logic       eop_next;
  logic       line_toggle_en;
  logic       line_force_se0;
  logic       line_force_j;

  // State, run-length counter, pending-last flag and the EOP pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ones_cnt  <= 3'd0;
      last_pend <= 1'b0;
      eop_done  <= 1'b0;
    end else begin
      state     <= state_next;
      ones_cnt  <= ones_next;
      last_pend <= last_pend_next;
      eop_done  <= eop_next;
    end
  end

  // Next-state, bit_req and line-control decode.
  always_comb begin
    state_next     = state;
    ones_next      = ones_cnt;
    last_pend_next = last_pend;
    eop_next       = 1'b0;
    bit_req        = 1'b0;
    line_toggle_en = 1'b0;
    line_force_se0 = 1'b0;
    line_force_j   = 1'b0;

    unique case (state)
      IDLE: begin
        // Keep J on the line and re-arm the NRZI reference for a packet.
        line_force_j = 1'b1;
        if (tx_start) begin
          state_next     = DATA;
          ones_next      = 3'd0;
          last_pend_next = 1'b0;
        end
      end

      DATA: begin
        if (shift_enable) begin
          bit_req = 1'b1;
          if (tx_bit) begin
            ones_next = ones_cnt + 3'd1;
          end else begin
            line_toggle_en = 1'b1;
            ones_next      = 3'd0;
          end
          if (tx_bit && (ones_cnt == STUFF_LIMIT - 3'd1)) begin
            // Sixth 1 in a row: the next slot is a stuffed 0. If this
            // was the final bit, the EOP must wait behind the stuff bit.
            state_next     = STUFF;
            last_pend_next = tx_last;
          end else if (tx_last) begin
            state_next = SE0_1;
          end
        end
      end

      STUFF: begin
        if (shift_enable) begin
          line_toggle_en = 1'b1;
          ones_next      = 3'd0;
          last_pend_next = 1'b0;
          state_next     = last_pend ? SE0_1 : DATA;
        end
      end

      SE0_1: begin
        if (shift_enable) begin
          line_force_se0 = 1'b1;
          state_next     = SE0_2;
        end
      end

      SE0_2: begin
        if (shift_enable) begin
          line_force_se0 = 1'b1;
          state_next     = EOP_J;
        end
      end

      EOP_J: begin
        if (shift_enable) begin
          line_force_j = 1'b1;
          eop_next     = 1'b1;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  usb_nrzi_enc u_nrzi (
    .clk        (clk),
    .rst        (rst),
    .toggle     (line_toggle_en),
    .force_se0  (line_force_se0),
    .force_j    (line_force_j),
    .dplus_out  (dplus_out),
    .dminus_out (dminus_out)
  );

  assign tx_busy   = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: doc/usb_tx_encode.md
USB_TX_ENCODE -- requirements
Module: usb_tx_encode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port shift_enable, input, 1 bit: one-cycle strobe per USB bit period from the external bit timer.
REQ-004 SHALL have port tx_start, input, 1 bit: request to begin a packet; sampled only in IDLE.
REQ-005 SHALL have port tx_bit, input, 1 bit: next unencoded data bit, LSB-first order, supplied by the upstream shifter.
REQ-006 SHALL have port tx_last, input, 1 bit: qualifies tx_bit as the final data bit of the packet.
REQ-007 SHALL have port bit_req, output, 1 bit: high in exactly the cycle tx_bit/tx_last are consumed.
REQ-008 SHALL have ports dplus_out and dminus_out, output, 1 bit each: registered USB line drive.
REQ-009 SHALL have port tx_busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port eop_done, output, 1 bit: one-cycle pulse when the EOP completes.

Function
REQ-011 SHALL implement the states IDLE, DATA, STUFF, SE0_1, SE0_2 and EOP_J.
REQ-012 SHALL take no state or line action on cycles where shift_enable=0, except the IDLE->DATA transition and reset.
REQ-013 SHALL move from IDLE to DATA on the edge where tx_start=1, without consuming a bit that cycle, even if shift_enable=1.
REQ-014 SHALL ignore tx_start outside IDLE.
REQ-015 SHALL, in DATA with shift_enable=1, assert bit_req combinationally and sample tx_bit and tx_last at that edge.
REQ-016 SHALL hold the line level for data bit 1 and toggle between J and K for data bit 0 (NRZI).
REQ-017 SHALL use J = (dplus_out=1, dminus_out=0), K = (0,1) and SE0 = (0,0).
REQ-018 SHALL update the line registers at the same edge the bit is consumed, giving one cycle of latency.
REQ-019 SHALL keep a 3-bit ones_cnt that increments on a transmitted 1 and clears on a transmitted 0 or a stuff bit.
REQ-020 SHALL go to STUFF on the edge where ones_cnt reaches 6.
REQ-021 SHALL, in STUFF at shift_enable, toggle the line, keep bit_req=0, clear ones_cnt, then go to DATA, or to SE0_1 if the last bit is pending.
REQ-022 SHALL go to SE0_1 after the bit sampled with tx_last=1, or after its stuff bit if one is required.
REQ-023 SHALL stuff a bit before the EOP when the final data bits end in six 1s.
REQ-024 SHALL drive SE0 for two bit periods (SE0_1, SE0_2), then J for one bit period (EOP_J).
REQ-025 SHALL, at the shift_enable that ends EOP_J, enter IDLE, pulse eop_done for one cycle and drop tx_busy in that same cycle.
REQ-026 SHALL drive J continuously in IDLE and reset the NRZI reference to J for every new packet.

Reset
REQ-027 SHALL, while rst=1 at any time including mid-packet, immediately force IDLE, J on the line (dplus_out=1, dminus_out=0), ones_cnt=0, tx_busy=0, bit_req=0 and eop_done=0.
REQ-028 SHALL resume normal operation at the first rising clk edge after rst falls.

Structure
REQ-029 SHALL place the state enum, STUFF_LIMIT=6 and the J/K/SE0 line-state constants in the shared package usb_pkg.
REQ-030 SHALL isolate the line register and its toggle/hold/force-SE0/force-J control in one sub-module, usb_nrzi_enc.
REQ-031 SHALL contain the FSM and ones_cnt in usb_tx_encode, so that usb_tx_encode mirrors the receive-side decode block.

Verification
REQ-032 SHALL test reset: rst=1 mid-packet -> next sample shows J, tx_busy=0, bit_req=0.
REQ-033 SHALL test the sync pattern: tx_start, then bits 0,0,0,0,0,0,0,1 -> line K,J,K,J,K,J,K,K, with bit_req high on 8 strobes.
REQ-034 SHALL test stuffing: eight 1s -> line J for 6 bit times, K on the stuff slot with bit_req=0, K for 2 more bit times, 9 bit periods total.
REQ-035 SHALL test the EOP: tx_last=1 on bit 0 -> SE0, SE0, J over the next 3 bit periods, then one eop_done pulse coinciding with tx_busy falling.
REQ-036 SHALL test a stuff bit before the EOP: six 1s with tx_last=1 on the 6th -> stuff toggle, then SE0, SE0, J.
REQ-037 SHALL test shift_enable gaps: 4-cycle gaps between strobes -> outputs stable between strobes and no extra bit_req.
